// File: rtl/riscv_alu_issue.sv
// RV32I ALU-instruction decode/issue stage: registered decode with valid/ready handshake.
// Optional second (skid) entry when RISCV_ALU_ISSUE_SKID_EN is defined.
module riscv_alu_issue #(
  parameter logic [4:0] ILLEGAL_CODE = 5'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  ALU_Ctrl,
  output logic [31:0] Imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        illegal
);

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  entry_t     dec;
  entry_t     out_q;
  logic       accept;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    dec         = '0;
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.rd      = inst[11:7];
    dec.ctrl    = ILLEGAL_CODE;
    dec.illegal = 1'b1;
    if (opcode == 7'b0110011) begin
      dec.illegal = 1'b0;
      case ({funct7, funct3})
        10'b0000000_000: dec.ctrl = 5'd1;
        10'b0100000_000: dec.ctrl = 5'd9;
        10'b0000000_110: dec.ctrl = 5'd3;
        10'b0000000_100: dec.ctrl = 5'd5;
        10'b0000000_111: dec.ctrl = 5'd7;
        10'b0000000_010: dec.ctrl = 5'd10;
        10'b0000000_011: dec.ctrl = 5'd12;
        10'b0000000_001: dec.ctrl = 5'd17;
        10'b0000000_101: dec.ctrl = 5'd18;
        10'b0100000_101: dec.ctrl = 5'd19;
        default: begin
          dec.ctrl    = ILLEGAL_CODE;
          dec.illegal = 1'b1;
        end
      endcase
    end else if (opcode == 7'b0010011) begin
      dec.illegal = 1'b0;
      dec.imm     = {{20{inst[31]}}, inst[31:20]};
      case (funct3)
        3'b000: dec.ctrl = 5'd2;
        3'b110: dec.ctrl = 5'd4;
        3'b100: dec.ctrl = 5'd6;
        3'b111: dec.ctrl = 5'd8;
        3'b010: dec.ctrl = 5'd11;
        3'b011: dec.ctrl = 5'd13;
        default: begin
          // Shift immediates carry only the 5-bit shamt; funct7 selects logical/arith.
          dec.imm = {27'd0, inst[24:20]};
          if (funct3 == 3'b001 && funct7 == 7'b0000000)      dec.ctrl = 5'd14;
          else if (funct3 == 3'b101 && funct7 == 7'b0000000) dec.ctrl = 5'd15;
          else if (funct3 == 3'b101 && funct7 == 7'b0100000) dec.ctrl = 5'd16;
          else begin
            dec.ctrl    = ILLEGAL_CODE;
            dec.imm     = '0;
            dec.illegal = 1'b1;
          end
        end
      endcase
    end
  end

  assign accept = in_valid && in_ready;

`ifdef RISCV_ALU_ISSUE_SKID_EN
  entry_t skid_q;
  logic   skid_valid;
  logic   drain;

  // in_ready depends only on the skid register, never on out_ready.
  assign in_ready = !skid_valid;
  assign drain    = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_q     <= dec;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign ALU_Ctrl = out_q.ctrl;
  assign Imm      = out_q.imm;
  assign rs1      = out_q.rs1;
  assign rs2      = out_q.rs2;
  assign rd       = out_q.rd;
  assign illegal  = out_q.illegal;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Directed self-checking bench for riscv_alu_issue (expectations follow RISCV_ALU_ISSUE_SKID_EN).
module tb_riscv_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  ALU_Ctrl;
  logic [31:0] Imm;
  logic [4:0]  rs1, rs2, rd;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  riscv_alu_issue #(.ILLEGAL_CODE(5'd0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Ctrl(ALU_Ctrl), .Imm(Imm), .rs1(rs1), .rs2(rs2), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

`ifdef RISCV_ALU_ISSUE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  ctrl;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        ill;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; inst = '0; flush = 1'b0; out_ready = 1'b1;
    #3;
    total++;
    if ({out_valid, ALU_Ctrl, Imm, rs1, rs2, rd, illegal} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {out_valid, ALU_Ctrl, Imm, rs1, rs2, rd, illegal});
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_decode();
    vec_t v[11];
    v = '{
      '{32'h002081B3, 5'd1,  32'h00000000, 5'd1, 5'd2,  5'd3, 1'b0},
      '{32'hFFF10093, 5'd2,  32'hFFFFFFFF, 5'd2, 5'd31, 5'd1, 1'b0},
      '{32'h4030D093, 5'd16, 32'h00000003, 5'd1, 5'd3,  5'd1, 1'b0},
      '{32'h00000073, 5'd0,  32'h00000000, 5'd0, 5'd0,  5'd0, 1'b1},
      '{32'h0220C0B3, 5'd0,  32'h00000000, 5'd1, 5'd2,  5'd1, 1'b1},
      '{32'h403100B3, 5'd9,  32'h00000000, 5'd2, 5'd3,  5'd1, 1'b0},
      '{32'h00509093, 5'd14, 32'h00000005, 5'd1, 5'd5,  5'd1, 1'b0},
      '{32'h7FF37293, 5'd8,  32'h000007FF, 5'd6, 5'd31, 5'd5, 1'b0},
      '{32'h4020D0B3, 5'd19, 32'h00000000, 5'd1, 5'd2,  5'd1, 1'b0},
      '{32'h00113093, 5'd13, 32'h00000001, 5'd2, 5'd1,  5'd1, 1'b0},
      '{32'h40509093, 5'd0,  32'h00000000, 5'd1, 5'd5,  5'd1, 1'b1}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; inst = v[i].inst;
      step();
      total++;
      if (out_valid !== 1'b1 || ALU_Ctrl !== v[i].ctrl || illegal !== v[i].ill) begin
        bad++; $display("FAIL decode_ctrl[%0d] got v=%b c=%0d ill=%b want v=1 c=%0d ill=%b",
                        i, out_valid, ALU_Ctrl, illegal, v[i].ctrl, v[i].ill);
      end
      total++;
      if (Imm !== v[i].imm) begin
        bad++; $display("FAIL decode_imm[%0d] got=%h want=%h", i, Imm, v[i].imm);
      end
      total++;
      if ({rs1, rs2, rd} !== {v[i].rs1, v[i].rs2, v[i].rd}) begin
        bad++; $display("FAIL decode_regs[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d",
                        i, rs1, rs2, rd, v[i].rs1, v[i].rs2, v[i].rd);
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL decode_idle got=%b want=0", out_valid); end
  endtask

  task automatic test_stall();
    logic [31:0] ins[3];
    logic [4:0]  ctl[3];
    int          idx;
    logic        take;
    ins = '{32'h002081B3, 32'hFFF10093, 32'h403100B3};
    ctl = '{5'd1, 5'd2, 5'd9};
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 3);
      inst     = (idx < 3) ? ins[idx] : 32'h0;
      take     = in_valid && in_ready;
      step();
      if (take) idx++;
      total++;
      if (out_valid !== 1'b1 || ALU_Ctrl !== 5'd1 || rd !== 5'd3 || Imm !== 32'd0) begin
        bad++; $display("FAIL stall_hold[%0d] got v=%b c=%0d rd=%0d imm=%h want v=1 c=1 rd=3 imm=0",
                        c, out_valid, ALU_Ctrl, rd, Imm);
      end
    end
    total++;
    if (idx !== CAP) begin bad++; $display("FAIL stall_accepted got=%0d want=%0d", idx, CAP); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < CAP; k++) begin
      total++;
      if (out_valid !== 1'b1 || ALU_Ctrl !== ctl[k]) begin
        bad++; $display("FAIL drain_order[%0d] got v=%b c=%0d want v=1 c=%0d", k, out_valid, ALU_Ctrl, ctl[k]);
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 32'h002081B3;
    step();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_setup got=%b want=1", out_valid); end
    flush = 1'b1; inst = 32'hFFF10093;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got=%b want=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ghost got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 32'h002081B3;
    step();
    inst = 32'h403100B3;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, ALU_Ctrl, Imm, rs1, rs2, rd, illegal} !== '0) begin
      bad++; $display("FAIL midreset_outputs got=%h want=0", {out_valid, ALU_Ctrl, Imm, rs1, rs2, rd, illegal});
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got=%b want=1", in_ready); end
    in_valid = 1'b1; inst = 32'h00509093;
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_xfer got=%b want=0", out_valid); end
    rst_n = 1'b1;
    in_valid = 1'b1; inst = 32'hFFF10093; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || ALU_Ctrl !== 5'd2 || Imm !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL postreset_first got v=%b c=%0d imm=%h want v=1 c=2 imm=ffffffff",
                      out_valid, ALU_Ctrl, Imm);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL postreset_empty got=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_stall();
    test_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_alu_issue.md
RISCV_ALU_ISSUE -- requirements
Module: riscv_alu_issue

Interface
REQ-001 SHALL have parameter: ILLEGAL_CODE, 0, ALU_Ctrl value issued for non-ALU or malformed instructions.
REQ-002 SHALL have ports (clock and reset first):
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instruction word present.
- in_ready  output  1  block accepts instruction this cycle.
- inst  input  32  RV32I instruction word.
- flush  input  1  discard all held entries.
- out_valid  output  1  decoded ALU operation present.
- out_ready  input  1  ALU stage consumes entry this cycle.
- ALU_Ctrl  output  5  operation code, 1..19 per REQ-007.
- Imm  output  32  operand immediate.
- rs1, rs2, rd  output  5 each  register indices.
- illegal  output  1  entry did not decode to an ALU operation.

Function
REQ-003 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready.
REQ-004 Latency: an accepted instruction SHALL appear on the outputs the next cycle; no combinational path from inst to any output.
REQ-005 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-006 Entries SHALL leave in acceptance order; none lost or duplicated.
REQ-007 Opcode 0110011 (R-type), funct7/funct3 -> ALU_Ctrl: 0000000/000 ADD=1, 0100000/000 SUB=9, 0000000/110 OR=3, 0000000/100 XOR=5, 0000000/111 AND=7, 0000000/010 SLT=10, 0000000/011 SLTU=12, 0000000/001 SLL=17, 0000000/101 SRL=18, 0100000/101 SRA=19.
REQ-008 Opcode 0010011 (I-type), funct3 -> ALU_Ctrl: 000 ADDI=2, 110 ORI=4, 100 XORI=6, 111 ANDI=8, 010 SLTI=11, 011 SLTIU=13; 001 with inst[31:25]=0000000 SLLI=14; 101 with 0000000 SRLI=15, with 0100000 SRAI=16.
REQ-009 Imm: I-type non-shift = sign-extended inst[31:20]; shift-immediate = zero-extended inst[24:20]; R-type = 0.
REQ-010 Any other opcode, funct7 or funct3 combination SHALL issue ALU_Ctrl=ILLEGAL_CODE, Imm=0, illegal=1; rs1/rs2/rd still = inst[19:15]/[24:20]/[11:7].
REQ-011 Without skid (REQ-016): one output register; in_ready = !out_valid || out_ready; accept and drain in the same cycle allowed.
REQ-012 flush SHALL clear out_valid (and skid entry) next edge; flush dominates a simultaneous input transfer (that instruction discarded); in_ready unaffected by flush.

Reset
REQ-013 rst_n low SHALL asynchronously force out_valid=0, ALU_Ctrl=0, Imm=0, rs1=rs2=rd=0, illegal=0, skid entry empty.
REQ-014 in_ready SHALL be 1 while in reset; no transfer counted while rst_n=0.
REQ-015 Reset asserted mid-stall SHALL discard held entries; first post-reset accept behaves as from empty.

Configuration
REQ-016 Macro RISCV_ALU_ISSUE_SKID_EN defined: a second (skid) entry is compiled in; in_ready = !skid_full, registered, no combinational path from out_ready; when an input transfers while output stalled, entry goes to skid and moves to output on the next drain; capacity 2.
REQ-017 Macro undefined: single entry per REQ-011, capacity 1; decode and ordering identical.

Verification
REQ-018 Scenarios:
- inst=0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, ALU_Ctrl=1, rs1=1, rs2=2, rd=3, Imm=0, illegal=0.
- inst=0xFFF10093 (addi x1,x2,-1) -> ALU_Ctrl=2, Imm=0xFFFFFFFF; inst=0x4030D093 (srai x1,x1,3) -> ALU_Ctrl=16, Imm=3.
- inst=0x00000073 (ecall) and inst=0x0220C0B3 (funct7=0000001) -> ALU_Ctrl=0, illegal=1.
- out_ready=0 for 5 cycles while 3 inputs offered -> outputs stable; SKID_EN: 2 accepted, in_ready=0; without: 1 accepted; release -> drained in order.
- flush with in_valid=1 and held entry -> next cycle out_valid=0, entry count 0.
- rst_n low mid-stall -> all outputs 0 immediately, in_ready=1.
